// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: buffers A and B, drives skewed
// row/column feeds and the array enable, accumulator-clear and result-capture strobes.
module systolic_seq_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = $clog2(3 * N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      m_cfg,
    input  logic [3:0]      k_cfg,
    input  logic [3:0]      p_cfg,
    input  logic            ld_valid,
    input  logic            ld_sel,
    input  logic            ld_clr,
    input  logic [DW-1:0]   ld_data,
    output logic            ld_ready,
    input  logic            start,
    output logic [N*DW-1:0] a_vec,
    output logic [N*DW-1:0] b_vec,
    output logic            sa_en,
    output logic            sa_clr,
    output logic            sa_load,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = $clog2(N + 1);

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StCapt, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] t_q, t_d;
    logic [3:0]    m_q, k_q, p_q;
    logic          err_q, err_d;

    logic [PW-1:0] a_row_q, a_row_d, a_col_q, a_col_d;
    logic [PW-1:0] b_row_q, b_row_d, b_col_q, b_col_d;

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [N][N];

    logic cfg_ok, t_last, start_acc, start_bad;
    logic ld_acc, a_ok, b_ok, a_col_last, b_col_last, a_we, b_we, drop;
    logic feed_d;

    assign ld_ready = (state_q == StIdle) || (state_q == StDone);
    // A start in the same cycle as a load wins; the load is not taken.
    assign ld_acc   = ld_valid && ld_ready && !start;

    assign cfg_ok = (m_cfg != 4'd0) && (32'(m_cfg) <= N) &&
                    (k_cfg != 4'd0) && (32'(k_cfg) <= N) &&
                    (p_cfg != 4'd0) && (32'(p_cfg) <= N);

    assign t_last = (32'(t_q) == 32'(m_q) + 32'(k_q) + 32'(p_q) - 32'd3);

    // Write windows follow the live cfg inputs; the run-time copy is taken only at start.
    assign a_ok = (32'(a_row_q) < 32'(m_cfg)) && (32'(a_row_q) < N) && (32'(a_col_q) < N);
    assign b_ok = (32'(b_row_q) < 32'(k_cfg)) && (32'(b_row_q) < N) && (32'(b_col_q) < N);
    assign a_col_last = (32'(a_col_q) + 32'd1 >= 32'(k_cfg));
    assign b_col_last = (32'(b_col_q) + 32'd1 >= 32'(p_cfg));

    always_comb begin
        a_row_d = a_row_q;
        a_col_d = a_col_q;
        b_row_d = b_row_q;
        b_col_d = b_col_q;
        a_we    = 1'b0;
        b_we    = 1'b0;
        drop    = 1'b0;
        if (ld_clr) begin
            a_row_d = '0;
            a_col_d = '0;
            b_row_d = '0;
            b_col_d = '0;
        end else if (ld_acc) begin
            if (!ld_sel) begin
                if (a_ok) begin
                    a_we = 1'b1;
                    if (a_col_last) begin
                        a_col_d = '0;
                        a_row_d = a_row_q + PW'(1);
                    end else begin
                        a_col_d = a_col_q + PW'(1);
                    end
                end else begin
                    drop = 1'b1;
                end
            end else begin
                if (b_ok) begin
                    b_we = 1'b1;
                    if (b_col_last) begin
                        b_col_d = '0;
                        b_row_d = b_row_q + PW'(1);
                    end else begin
                        b_col_d = b_col_q + PW'(1);
                    end
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        start_acc = 1'b0;
        start_bad = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (cfg_ok) begin
                        start_acc = 1'b1;
                        state_d   = StClear;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            StClear: begin
                state_d = StFeed;
                t_d     = '0;
            end
            StFeed: begin
                if (t_last) begin
                    state_d = StCapt;
                end else begin
                    t_d = t_q + CW'(1);
                end
            end
            StCapt:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end
        if (start_bad || drop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            t_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
            a_row_q <= '0;
            a_col_q <= '0;
            b_row_q <= '0;
            b_col_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            err_q   <= err_d;
            a_row_q <= a_row_d;
            a_col_q <= a_col_d;
            b_row_q <= b_row_d;
            b_col_q <= b_col_d;
            if (start_acc) begin
                m_q <= m_cfg;
                k_q <= k_cfg;
                p_q <= p_cfg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_mem <= '{default: '0};
            b_mem <= '{default: '0};
        end else begin
            if (a_we) a_mem[a_row_q[IW-1:0]][a_col_q[IW-1:0]] <= ld_data;
            if (b_we) b_mem[b_row_q[IW-1:0]][b_col_q[IW-1:0]] <= ld_data;
        end
    end

    // Lanes are registered from next-state so they line up with sa_en in FEED cycle t.
    assign feed_d = (state_d == StFeed);

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [CW-1:0] off;
        logic          in_k, a_hit, b_hit;
        logic [DW-1:0] a_lane_q, b_lane_q;

        assign off   = t_d - CW'(g);
        assign in_k  = (32'(t_d) >= 32'(g)) && (32'(off) < 32'(k_q));
        assign a_hit = feed_d && in_k && (32'(g) < 32'(m_q));
        assign b_hit = feed_d && in_k && (32'(g) < 32'(p_q));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_lane_q <= '0;
                b_lane_q <= '0;
            end else begin
                a_lane_q <= a_hit ? a_mem[g][off[IW-1:0]] : '0;
                b_lane_q <= b_hit ? b_mem[off[IW-1:0]][g] : '0;
            end
        end

        assign a_vec[g*DW +: DW] = a_lane_q;
        assign b_vec[g*DW +: DW] = b_lane_q;
    end

    assign sa_clr  = (state_q == StClear);
    assign sa_en   = (state_q == StFeed);
    assign sa_load = (state_q == StCapt);
    assign busy    = (state_q == StClear) || (state_q == StFeed) || (state_q == StCapt);
    assign done    = (state_q == StDone);
    assign err     = err_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: skewed feeds, strobe timing, load window, errors, reset.
module tb_systolic_seq_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned VW = N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    m_cfg = 4'd0, k_cfg = 4'd0, p_cfg = 4'd0;
    logic          ld_valid = 1'b0, ld_sel = 1'b0, ld_clr = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          start = 1'b0;
    logic          ld_ready, sa_en, sa_clr, sa_load, busy, done, err;
    logic [VW-1:0] a_vec, b_vec;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] a_hist [16];
    logic [VW-1:0] b_hist [16];
    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];
    int            en;

    systolic_seq_ctrl #(.N(N), .DW(DW)) dut (
        .clk(clk), .reset(reset), .m_cfg(m_cfg), .k_cfg(k_cfg), .p_cfg(p_cfg),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_clr(ld_clr), .ld_data(ld_data),
        .ld_ready(ld_ready), .start(start), .a_vec(a_vec), .b_vec(b_vec), .sa_en(sa_en),
        .sa_clr(sa_clr), .sa_load(sa_load), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [DW-1:0] d);
        ld_sel   = sel;
        ld_data  = d;
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic clr_ptrs();
        ld_clr = 1'b1;
        step();
        ld_clr = 1'b0;
    endtask

    task automatic set_cfg(input logic [3:0] m, input logic [3:0] k, input logic [3:0] p);
        m_cfg = m;
        k_cfg = k;
        p_cfg = p;
    endtask

    // One multiply from an accepted start; records every sa_en cycle's feed vectors.
    // With poke set, start and a load are raised during the first FEED cycle.
    task automatic run(input bit poke, output int n_en);
        for (int k = 0; k < 16; k++) begin
            a_hist[k] = '0;
            b_hist[k] = '0;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk_bit("sa_clr", sa_clr, 1'b1);
        chk_bit("err_cleared", err, 1'b0);
        chk_bit("done_low_in_clear", done, 1'b0);
        n_en = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            start    = 1'b0;
            ld_valid = 1'b0;
            if (!sa_en) break;
            if (n_en < 16) begin
                a_hist[n_en] = a_vec;
                b_hist[n_en] = b_vec;
            end
            n_en++;
            if (poke && n_en == 1) begin
                start    = 1'b1;
                ld_valid = 1'b1;
                ld_sel   = 1'b0;
                ld_data  = 32'd99;
                chk_bit("ld_ready_busy", ld_ready, 1'b0);
            end
        end
        chk_bit("sa_load", sa_load, 1'b1);
        chk_vec("capt_a_zero", a_vec, '0);
        step();
        chk_bit("done", done, 1'b1);
        chk_bit("ld_ready_done", ld_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [VW-1:0] ea, eb;
        logic [DW-1:0] acc, ref_c;

        // Reset state
        #3;
        chk_bit("rst_ld_ready", ld_ready, 1'b1);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_err", err, 1'b0);
        chk_bit("rst_sa_en", sa_en, 1'b0);
        chk_vec("rst_a_vec", a_vec, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 2x2 multiply with hand-computed feeds
        set_cfg(4'd2, 4'd2, 4'd2);
        clr_ptrs();
        wr(1'b0, 32'd1); wr(1'b0, 32'd2); wr(1'b0, 32'd3); wr(1'b0, 32'd4);
        wr(1'b1, 32'd5); wr(1'b1, 32'd6); wr(1'b1, 32'd7); wr(1'b1, 32'd8);
        run(1'b0, en);
        chk_int("t2_en_cycles", en, 4);
        chk_vec("t2_a_c2", a_hist[0], {32'd0, 32'd0, 32'd0, 32'd1});
        chk_vec("t2_b_c2", b_hist[0], {32'd0, 32'd0, 32'd0, 32'd5});
        chk_vec("t2_a_c3", a_hist[1], {32'd0, 32'd0, 32'd3, 32'd2});
        chk_vec("t2_b_c3", b_hist[1], {32'd0, 32'd0, 32'd6, 32'd7});
        chk_vec("t2_a_c4", a_hist[2], {32'd0, 32'd0, 32'd4, 32'd0});
        chk_vec("t2_b_c4", b_hist[2], {32'd0, 32'd0, 32'd8, 32'd0});
        chk_vec("t2_a_c5", a_hist[3], '0);
        chk_vec("t2_b_c5", b_hist[3], '0);

        // Reset in the middle of FEED aborts at once
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk_vec("t1_feed_nonzero", a_vec, {32'd0, 32'd0, 32'd0, 32'd1});
        step();
        #2 reset = 1'b0;
        #1;
        chk_bit("t1_feed_rst_sa_en", sa_en, 1'b0);
        chk_bit("t1_feed_rst_busy", busy, 1'b0);
        chk_bit("t1_feed_rst_ld_ready", ld_ready, 1'b1);
        chk_vec("t1_feed_rst_a", a_vec, '0);
        chk_vec("t1_feed_rst_b", b_vec, '0);
        step();
        chk_bit("t1_no_sa_load", sa_load, 1'b0);
        reset = 1'b1;

        // Reset in the middle of a load
        wr(1'b0, 32'h55);
        ld_sel   = 1'b0;
        ld_data  = 32'h66;
        ld_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk_bit("t1_load_rst_ld_ready", ld_ready, 1'b1);
        chk_bit("t1_load_rst_done", done, 1'b0);
        chk_bit("t1_load_rst_err", err, 1'b0);
        ld_valid = 1'b0;
        step();
        reset = 1'b1;
        run(1'b0, en);
        chk_int("t1_rb_en_cycles", en, 4);
        for (int t = 0; t < 4; t++) begin
            chk_vec("t1_rb_a_zero", a_hist[t], '0);
            chk_vec("t1_rb_b_zero", b_hist[t], '0);
        end

        // 4x4 random data: skew formula and array-model product
        set_cfg(4'd4, 4'd4, 4'd4);
        clr_ptrs();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = $urandom_range(0, 1000);
                wr(1'b0, ma[i][k]);
            end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) begin
                mb[k][j] = $urandom_range(0, 1000);
                wr(1'b1, mb[k][j]);
            end
        run(1'b0, en);
        chk_int("t3_en_cycles", en, 10);
        for (int t = 0; t < 10; t++) begin
            ea = '0;
            eb = '0;
            for (int i = 0; i < 4; i++) begin
                if (t >= i && t - i < 4) begin
                    ea[i*DW +: DW] = ma[i][t-i];
                    eb[i*DW +: DW] = mb[t-i][i];
                end
            end
            chk_vec("t3_a_skew", a_hist[t], ea);
            chk_vec("t3_b_skew", b_hist[t], eb);
        end
        // PE(i,j) sees row lane i delayed by j and column lane j delayed by i
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc   = '0;
                ref_c = '0;
                for (int t = 0; t < 10; t++)
                    if (t >= i && t >= j)
                        acc += a_hist[t-j][i*DW +: DW] * b_hist[t-i][j*DW +: DW];
                for (int k = 0; k < 4; k++)
                    ref_c += ma[i][k] * mb[k][j];
                chk_word("t3_c", acc, ref_c);
            end

        // Overflowing load, ld_clr priority
        set_cfg(4'd2, 4'd2, 4'd2);
        clr_ptrs();
        wr(1'b0, 32'd11); wr(1'b0, 32'd12); wr(1'b0, 32'd13); wr(1'b0, 32'd14);
        chk_bit("t4_err_before", err, 1'b0);
        wr(1'b0, 32'd15);
        chk_bit("t4_err_overflow", err, 1'b1);
        ld_clr   = 1'b1;
        ld_sel   = 1'b0;
        ld_data  = 32'd77;
        ld_valid = 1'b1;
        step();
        ld_clr   = 1'b0;
        ld_valid = 1'b0;
        wr(1'b0, 32'd21);
        wr(1'b1, 32'd1); wr(1'b1, 32'd0); wr(1'b1, 32'd0); wr(1'b1, 32'd1);
        run(1'b0, en);
        chk_vec("t4_a_t0", a_hist[0], {32'd0, 32'd0, 32'd0, 32'd21});
        chk_vec("t4_a_t1", a_hist[1], {32'd0, 32'd0, 32'd13, 32'd12});
        chk_vec("t4_b_t2", b_hist[2], {32'd0, 32'd0, 32'd1, 32'd0});

        // Illegal cfg at start; start and load while busy
        set_cfg(4'd2, 4'd0, 4'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_bit("t5_k0_err", err, 1'b1);
        chk_bit("t5_k0_sa_clr", sa_clr, 1'b0);
        chk_bit("t5_k0_busy", busy, 1'b0);
        chk_bit("t5_k0_done_held", done, 1'b1);
        set_cfg(4'd5, 4'd2, 4'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_bit("t5_m5_err", err, 1'b1);
        chk_bit("t5_m5_sa_clr", sa_clr, 1'b0);
        set_cfg(4'd2, 4'd2, 4'd2);
        run(1'b1, en);
        chk_int("t5_busy_start_en", en, 4);
        run(1'b0, en);
        chk_vec("t5_mem_kept_t0", a_hist[0], {32'd0, 32'd0, 32'd0, 32'd21});
        chk_vec("t5_mem_kept_t1", a_hist[1], {32'd0, 32'd0, 32'd13, 32'd12});

        // Back-to-back runs with start held high
        start = 1'b1;
        step();
        chk_bit("t6_sa_clr1", sa_clr, 1'b1);
        en = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!sa_en) break;
            en++;
        end
        chk_int("t6_en1", en, 4);
        chk_bit("t6_load1", sa_load, 1'b1);
        step();
        chk_bit("t6_done1", done, 1'b1);
        step();
        chk_bit("t6_done_drop", done, 1'b0);
        chk_bit("t6_sa_clr2", sa_clr, 1'b1);
        start = 1'b0;
        en = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!sa_en) break;
            en++;
        end
        chk_int("t6_en2", en, 4);
        chk_bit("t6_load2", sa_load, 1'b1);
        step();
        chk_bit("t6_done2", done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
